// File: rtl/kband_pio_ctrl.sv
// Avalon-MM parallel I/O controller: output register with atomic set/clear,
// synchronised input port with rising-edge capture, and a maskable registered irq.
module kband_pio_ctrl #(
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0,
  parameter int                SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port,
  output logic              irq
);

  logic                                wr_stb;
  logic                                rd_stb;
  logic [DATA_W-1:0]                   wd;
  logic [DATA_W-1:0]                   out_reg;
  logic [DATA_W-1:0]                   out_next;
  logic [DATA_W-1:0]                   mask_reg;
  logic [DATA_W-1:0]                   mask_next;
  logic [DATA_W-1:0]                   edge_cap;
  logic [DATA_W-1:0]                   edge_next;
  logic [DATA_W-1:0]                   edge_clr;
  logic [DATA_W-1:0]                   prev;
  logic [DATA_W-1:0]                   sync_in;
  logic [DATA_W-1:0]                   rise;
  logic [SYNC_STAGES-1:0][DATA_W-1:0]  sync_chain;
  logic [31:0]                         rd_word;
  logic                                irq_next;

  assign wr_stb   = chipselect & ~write_n;
  assign rd_stb   = chipselect & ~read_n;
  assign wd       = writedata[DATA_W-1:0];
  assign sync_in  = sync_chain[SYNC_STAGES-1];
  assign out_port = out_reg;
  assign irq_next = |(edge_cap & mask_reg);

  // Capture set is ORed in last so a fresh rise beats a same-cycle W1C.
  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_edge
      assign rise[gi]      = sync_in[gi] & ~prev[gi];
      assign edge_next[gi] = (edge_cap[gi] & ~edge_clr[gi]) | rise[gi];
    end
  endgenerate

  always_comb begin
    out_next  = out_reg;
    mask_next = mask_reg;
    edge_clr  = '0;
    if (wr_stb) begin
      case (address)
        3'd0:    out_next  = wd;
        3'd2:    mask_next = wd;
        3'd3:    edge_clr  = wd;
        3'd4:    out_next  = out_reg | wd;
        3'd5:    out_next  = out_reg & ~wd;
        default: ;
      endcase
    end
  end

  // Read mux sees pre-edge register values, so a colliding write is not visible.
  always_comb begin
    rd_word = '0;
    case (address)
      3'd0:    rd_word[DATA_W-1:0] = out_reg;
      3'd1:    rd_word[DATA_W-1:0] = sync_in;
      3'd2:    rd_word[DATA_W-1:0] = mask_reg;
      3'd3:    rd_word[DATA_W-1:0] = edge_cap;
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_reg    <= RESET_VAL;
      mask_reg   <= '0;
      edge_cap   <= '0;
      prev       <= '0;
      sync_chain <= '0;
      readdata   <= '0;
      irq        <= 1'b0;
    end else begin
      out_reg  <= out_next;
      mask_reg <= mask_next;
      edge_cap <= edge_next;
      prev     <= sync_in;
      irq      <= irq_next;
      if (SYNC_STAGES > 1)
        sync_chain <= {sync_chain[SYNC_STAGES-2:0], in_port};
      else
        sync_chain <= in_port;
      if (rd_stb)
        readdata <= rd_word;
    end
  end

endmodule
